mux42_rr_arb: RTL

MUX42_RR_ARB -- requirements
Module: mux42_rr_arb

---
 rtl/mux_arb_pkg.sv | 22 ++
 rtl/m_mux42.sv | 16 +
 rtl/mux42_rr_arb.sv | 94 +++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and sizes for the 4-way round-robin data arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 2;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/m_mux42.sv
// 4:1 selector of DATA_W-bit words packed into one bus, word i at bits [DATA_W*i +: DATA_W].
// Latency: combinational.
// Backpressure: none.
module m_mux42
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ*DATA_W-1:0] d,
    input  logic [SEL_W-1:0]          s,
    output logic [DATA_W-1:0]         y
);

    always_comb begin
        y = d[s*DATA_W +: DATA_W];
    end

endmodule

// File: rtl/mux42_rr_arb.sv
// Round-robin grant of one of four requesters; the granted word is held until taken or timed out.
// Latency: out_valid one cycle after req seen in IDLE; at most one transfer per two cycles.
// Backpressure: holds y/sel/gnt while out_ready=0; abandons after TIMEOUT stalled cycles (0 = never).
module mux42_rr_arb
    import mux_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] a,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         y,
    output logic [SEL_W-1:0]          sel,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      tmo
);

    localparam bit         TMO_EN   = (TIMEOUT != 0);
    localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

    arb_state_t        state;
    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  nxt_idx;
    logic [SEL_W-1:0]  cand;
    logic [3:0]        cnt;
    logic [DATA_W-1:0] nxt_y;
    logic              xfer;
    logic              tmo_fire;

    // Scan from the highest offset down so the nearest set bit after ptr wins.
    always_comb begin
        nxt_idx = ptr;
        cand    = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                nxt_idx = cand;
            end
        end
    end

    m_mux42 u_mux (
        .d (a),
        .s (nxt_idx),
        .y (nxt_y)
    );

    // cnt counts stalled BUSY cycles already elapsed, so the stall that fires is the TIMEOUT-th.
    assign xfer     = (state == BUSY) && out_ready;
    assign tmo_fire = TMO_EN && (state == BUSY) && !out_ready && (cnt == TMO_LAST);
    assign ack      = xfer ? gnt : '0;
    assign tmo      = tmo_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            y         <= '0;
            sel       <= '0;
            gnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        sel       <= nxt_idx;
                        y         <= nxt_y;
                        gnt       <= onehot(nxt_idx);
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (xfer || tmo_fire) begin
                        ptr       <= sel + 1'b1;
                        out_valid <= 1'b0;
                        gnt       <= '0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
